// File: rtl/alu_issue_ctrl.sv
// Issue controller for a 6-bit ripple ALU: it holds the operands steady while the ALU ripple
// settles, then registers the response. The out_ovf flag is built only with ALU_OVERFLOW_FLAG_EN.
module alu_issue_ctrl #(
  parameter int WIDTH         = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [3:0]       in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero
`ifdef ALU_OVERFLOW_FLAG_EN
  ,output logic            out_ovf
`endif
);

  localparam int         MSB      = WIDTH - 1;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       accept, capture;

  assign in_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE:   if (in_valid) begin accept = 1'b1; state_nxt = SETTLE; end
      SETTLE: if (cnt == 4'd0) begin capture = 1'b1; state_nxt = HOLD; end
      HOLD:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  // Signed overflow is judged against the operands that are actually driving the ALU.
  logic ovf_nxt;
  always_comb begin
    ovf_nxt = 1'b0;
    case (alu_op)
      4'b0010: ovf_nxt = (alu_a[MSB] == alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
      4'b0110: ovf_nxt = (alu_a[MSB] != alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
      default: ovf_nxt = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      alu_op     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
      out_ovf    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a   <= in_a;
        alu_b   <= in_b;
        alu_cin <= in_cin;
        alu_op  <= in_op;
        cnt     <= CNT_INIT;
      end else if (state == SETTLE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        out_valid  <= 1'b1;
        out_result <= alu_result;
        out_carry  <= alu_carry;
        out_zero   <= (alu_result == '0);
`ifdef ALU_OVERFLOW_FLAG_EN
        out_ovf    <= ovf_nxt;
`endif
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a default-settle instance and a SETTLE_CYCLES=1 instance,
// each driven through a behavioural ripple-ALU model.
module tb_alu_issue_ctrl;
  localparam int W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, in_valid, in_ready, in_cin, alu_cin, alu_carry, out_valid, out_ready;
  logic out_carry, out_zero;
  logic [W-1:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
  logic [3:0] in_op, alu_op;

  logic v1, rdy1, cin1, ready1, acin1, acarry1, ov1, oc1, oz1;
  logic [W-1:0] a1, b1, aa1, ab1, ares1, ores1;
  logic [3:0] op1, aop1;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic out_ovf, oovf1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [W:0] alu_f(input logic [W-1:0] a, b, input logic c, input logic [3:0] op);
    case (op)
      4'b0000: alu_f = {1'b0, a & b};
      4'b0001: alu_f = {1'b0, a | b};
      4'b0010: alu_f = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      4'b0110: alu_f = {1'b0, a} + {1'b0, ~b} + 1;
      default: alu_f = {1'b0, a ^ b};
    endcase
  endfunction

  assign {alu_carry, alu_result} = alu_f(alu_a, alu_b, alu_cin, alu_op);
  assign {acarry1, ares1}        = alu_f(aa1, ab1, acin1, aop1);

  alu_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero)
`ifdef ALU_OVERFLOW_FLAG_EN
    , .out_ovf(out_ovf)
`endif
  );

  alu_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_ready(rdy1),
    .in_a(a1), .in_b(b1), .in_cin(cin1), .in_op(op1),
    .alu_a(aa1), .alu_b(ab1), .alu_cin(acin1), .alu_op(aop1),
    .alu_result(ares1), .alu_carry(acarry1),
    .out_valid(ov1), .out_ready(ready1),
    .out_result(ores1), .out_carry(oc1), .out_zero(oz1)
`ifdef ALU_OVERFLOW_FLAG_EN
    , .out_ovf(oovf1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [W-1:0] a, b, input logic c, input logic [3:0] op);
    in_a = a; in_b = b; in_cin = c; in_op = op; in_valid = 1'b1;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    chk("pop_valid_clear", out_valid, 0);
    chk("pop_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_op = '0;
    v1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; op1 = '0; ready1 = 1'b0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_flags", {out_carry, out_zero}, 0);
    reset_n = 1'b1;

    // add 20+15 with latency check: accept at edge N, valid after N+2
    present(6'd20, 6'd15, 1'b0, 4'b0010);
    tick();
    in_valid = 1'b0;
    chk("add_busy", in_ready, 0);
    chk("add_alu_a", alu_a, 20);
    chk("add_alu_op", alu_op, 4'b0010);
    chk("add_n0_valid", out_valid, 0);
    tick();
    chk("add_n1_valid", out_valid, 0);
    tick();
    chk("add_n2_valid", out_valid, 1);
    chk("add_result", out_result, 35);
    chk("add_cz", {out_carry, out_zero}, 2'b00);
    pop();

    // carry-out with zero result
    present(6'h3F, 6'h01, 1'b0, 4'b0010);
    tick(); in_valid = 1'b0; tick(); tick();
    chk("cz_valid", out_valid, 1);
    chk("cz_result", out_result, 0);
    chk("cz_cz", {out_carry, out_zero}, 2'b11);
`ifdef ALU_OVERFLOW_FLAG_EN
    chk("cz_ovf", out_ovf, 0);
`endif
    pop();

    // signed overflow on add and sub
    present(6'd31, 6'd1, 1'b0, 4'b0010);
    tick(); in_valid = 1'b0; tick(); tick();
    chk("ovf_add_result", out_result, 32);
`ifdef ALU_OVERFLOW_FLAG_EN
    chk("ovf_add_flag", out_ovf, 1);
`endif
    pop();
    present(6'd32, 6'd1, 1'b0, 4'b0110);
    tick(); in_valid = 1'b0;
    chk("sub_op_pass", alu_op, 4'b0110);
    tick(); tick();
    chk("ovf_sub_result", out_result, 31);
`ifdef ALU_OVERFLOW_FLAG_EN
    chk("ovf_sub_flag", out_ovf, 1);
`endif
    pop();

    // backpressure with the next request waiting upstream the whole time
    present(6'd5, 6'd9, 1'b0, 4'b0010);
    tick();
    present(6'd7, 6'd8, 1'b0, 4'b0010);
    tick(); tick();
    chk("bp_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", out_result, 14);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_alu_a", alu_a, 5);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_xfer_valid", out_valid, 0);
    chk("bp_xfer_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_accept", alu_a, 7);
    chk("bp_second_busy", in_ready, 0);
    tick(); tick();
    chk("bp_second_result", out_result, 15);
    pop();

    // reset during SETTLE discards the request
    present(6'd3, 6'd4, 1'b0, 4'b0010);
    tick();
    in_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_result", out_result, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_no_valid", out_valid, 0);
    end
    // out_ready while idle does nothing
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_ready_valid", out_valid, 0);
    chk("idle_ready_in_ready", in_ready, 1);

    // SETTLE_CYCLES=1 instance: valid right after edge N+1
    a1 = 6'd10; b1 = 6'd11; cin1 = 1'b1; op1 = 4'b0010; v1 = 1'b1;
    tick();
    v1 = 1'b0; a1 = 6'h3F;
    chk("s1_n0_valid", ov1, 0);
    chk("s1_alu_a", aa1, 10);
    tick();
    chk("s1_n1_valid", ov1, 1);
    chk("s1_result", ores1, 22);
    chk("s1_alu_stable", aa1, 10);
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    chk("s1_pop", ov1, 0);
    chk("s1_in_ready", rdy1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
